// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a borrow flop,
// LSB first, with a start/busy/done handshake around a three-state controller.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, rr_q, rr_d, d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             x, br_next;

  assign x       = ra_q[0] ^ rb_q[0] ^ br_q;
  assign br_next = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          ra_d    = a;
          rb_d    = b;
          // Operand MSBs are kept aside since ra/rb are consumed by the shift.
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        rr_d  = {x, rr_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          d_d     = {x, rr_q[WIDTH-1:1]};
          bout_d  = br_next;
          ovf_d   = (a_msb_q ^ b_msb_q) & (x ^ a_msb_q);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
